// File: rtl/sb_param_pkg.sv
// Shared types and constants for the parametrised corner switch block.
// Holds the config-load FSM states, default sizes and the bitstream-length helper.
package sb_param_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FULL = 2'd2
   } cfg_state_t;

   localparam int CHAN_W_DEF = 11;
   localparam int N_PINS_DEF = 6;
   localparam int SEL_W_DEF  = 3;

   // One select field per driven track, top side plus right side.
   function automatic int sb_cfg_bits(input int chan_w, input int sel_w);
      return 2 * chan_w * sel_w;
   endfunction

endpackage

// File: rtl/sb_cfg_chain.sv
// Serial configuration chain with bit counter, load FSM, shadow register and error flag.
// Optional even-parity bit on the chain when SB_CFG_PARITY_EN is defined.
//
// state | meaning
// IDLE  | no bits loaded since the last commit or reset
// LOAD  | partial bitstream in the chain
// FULL  | exactly one bitstream loaded, commit allowed
module sb_cfg_chain
   import sb_param_pkg::*;
#(
   parameter int TOTAL = 66
) (
   input  logic             prog_clk,
   input  logic             prog_reset_n,
   input  logic             ccff_head,
   input  logic             ccff_shift_en,
   input  logic             cfg_commit,
   output logic [TOTAL-1:0] shadow,
   output logic             ccff_tail,
   output logic             cfg_done,
   output logic             cfg_err
);

`ifdef SB_CFG_PARITY_EN
   localparam int CL = TOTAL + 1;
`else
   localparam int CL = TOTAL;
`endif
   localparam int CW = $clog2(CL + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(CL);
   localparam logic [CW-1:0] CNT_LAST = CW'(CL - 1);

   cfg_state_t    state, state_nxt;
   logic [CL-1:0] chain;
   logic [CW-1:0] cnt;
   logic          parity_ok;
   logic          commit_ok;
   logic          err_set;

`ifdef SB_CFG_PARITY_EN
   assign parity_ok = ~(^chain);
`else
   assign parity_ok = 1'b1;
`endif

   always_comb begin
      state_nxt = state;
      commit_ok = 1'b0;
      err_set   = 1'b0;
      // A commit is only honoured on a quiet, complete, parity-clean chain.
      if (cfg_commit) begin
         if (state == FULL && !ccff_shift_en && parity_ok)
            commit_ok = 1'b1;
         else
            err_set = 1'b1;
      end
      if (ccff_shift_en && cnt == CNT_FULL)
         err_set = 1'b1;
      case (state)
         IDLE:    if (ccff_shift_en) state_nxt = LOAD;
         LOAD:    if (ccff_shift_en && cnt == CNT_LAST) state_nxt = FULL;
         FULL:    if (commit_ok) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign cfg_done = (state == FULL);

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         state     <= IDLE;
         chain     <= '0;
         cnt       <= '0;
         shadow    <= '0;
         ccff_tail <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (ccff_shift_en) begin
            chain     <= {chain[CL-2:0], ccff_head};
            ccff_tail <= chain[CL-1];
            if (cnt != CNT_FULL)
               cnt <= cnt + CW'(1);
         end
         if (commit_ok) begin
            shadow <= chain[TOTAL-1:0];
            cnt    <= '0;
         end
         if (err_set)
            cfg_err <= 1'b1;
      end
   end

endmodule

// File: rtl/sb_corner_param.sv
// Bottom-left corner switch block: select-muxes on every top/right track, selects from a shadowed config chain.
// Build option: SB_CFG_PARITY_EN adds a parity bit to the configuration chain.
module sb_corner_param
   import sb_param_pkg::*;
#(
   parameter int CHAN_W = CHAN_W_DEF,
   parameter int N_PINS = N_PINS_DEF,
   parameter int SEL_W  = SEL_W_DEF
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              ccff_head,
   input  logic              ccff_shift_en,
   input  logic              cfg_commit,
   input  logic [CHAN_W-1:0] chany_top_in,
   input  logic [CHAN_W-1:0] chanx_right_in,
   input  logic              top_pin_in,
   input  logic [N_PINS-1:0] right_pin_in,
   output logic [CHAN_W-1:0] chany_top_out,
   output logic [CHAN_W-1:0] chanx_right_out,
   output logic              ccff_tail,
   output logic              cfg_done,
   output logic              cfg_err
);

   localparam int TOTAL = sb_cfg_bits(CHAN_W, SEL_W);

   logic [TOTAL-1:0] shadow;

   sb_cfg_chain #(.TOTAL(TOTAL)) u_cfg_chain (
      .prog_clk      (prog_clk),
      .prog_reset_n  (prog_reset_n),
      .ccff_head     (ccff_head),
      .ccff_shift_en (ccff_shift_en),
      .cfg_commit    (cfg_commit),
      .shadow        (shadow),
      .ccff_tail     (ccff_tail),
      .cfg_done      (cfg_done),
      .cfg_err       (cfg_err)
   );

   for (genvar j = 0; j < CHAN_W; j++) begin : g_top
      logic [SEL_W-1:0] sel;
      assign sel = shadow[j*SEL_W +: SEL_W];
      assign chany_top_out[j] = (sel == '0)         ? chanx_right_in[j] :
                                (sel == SEL_W'(1))  ? top_pin_in        : 1'b0;
   end

   // Unused select codes above N_PINS park the track at 0.
   for (genvar i = 0; i < CHAN_W; i++) begin : g_right
      logic [SEL_W-1:0] sel;
      logic             mux_o;
      assign sel = shadow[(CHAN_W+i)*SEL_W +: SEL_W];
      always_comb begin
         mux_o = 1'b0;
         if (sel == '0)
            mux_o = chany_top_in[i];
         for (int k = 0; k < N_PINS; k++)
            if (sel == SEL_W'(k + 1))
               mux_o = right_pin_in[k];
      end
      assign chanx_right_out[i] = mux_o;
   end

endmodule

// File: tb/tb_sb_corner_param.sv
// Randomised bench for sb_corner_param against a bit-history reference model.
// Honours SB_CFG_PARITY_EN the same way as the design.
module tb_sb_corner_param;

   localparam int CHAN_W = 11;
   localparam int N_PINS = 6;
   localparam int SEL_W  = 3;
   localparam int TOTAL  = 2 * CHAN_W * SEL_W;
   localparam int NMUX   = 2 * CHAN_W;
`ifdef SB_CFG_PARITY_EN
   localparam int CL = TOTAL + 1;
`else
   localparam int CL = TOTAL;
`endif

   logic              prog_clk = 1'b0;
   logic              prog_reset_n;
   logic              ccff_head;
   logic              ccff_shift_en;
   logic              cfg_commit;
   logic [CHAN_W-1:0] chany_top_in;
   logic [CHAN_W-1:0] chanx_right_in;
   logic              top_pin_in;
   logic [N_PINS-1:0] right_pin_in;
   logic [CHAN_W-1:0] chany_top_out;
   logic [CHAN_W-1:0] chanx_right_out;
   logic              ccff_tail;
   logic              cfg_done;
   logic              cfg_err;

   sb_corner_param #(.CHAN_W(CHAN_W), .N_PINS(N_PINS), .SEL_W(SEL_W)) dut (
      .prog_clk        (prog_clk),
      .prog_reset_n    (prog_reset_n),
      .ccff_head       (ccff_head),
      .ccff_shift_en   (ccff_shift_en),
      .cfg_commit      (cfg_commit),
      .chany_top_in    (chany_top_in),
      .chanx_right_in  (chanx_right_in),
      .top_pin_in      (top_pin_in),
      .right_pin_in    (right_pin_in),
      .chany_top_out   (chany_top_out),
      .chanx_right_out (chanx_right_out),
      .ccff_tail       (ccff_tail),
      .cfg_done        (cfg_done),
      .cfg_err         (cfg_err)
   );

   always #5 prog_clk = ~prog_clk;

   int total = 0;
   int bad   = 0;

   // Reference model: every bit shifted since reset, in arrival order.
   bit hist[$];
   int m_sel[NMUX];
   int m_cnt;
   bit m_err;
   int sels[NMUX];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   function automatic bit m_chain(input int k);
      int idx;
      idx = hist.size() - 1 - k;
      return (idx >= 0) ? hist[idx] : 1'b0;
   endfunction

   function automatic bit m_parity_ok();
`ifdef SB_CFG_PARITY_EN
      bit x;
      x = 1'b0;
      for (int k = 0; k < CL; k++) x ^= m_chain(k);
      return !x;
`else
      return 1'b1;
`endif
   endfunction

   function automatic void m_reset();
      hist.delete();
      for (int j = 0; j < NMUX; j++) m_sel[j] = 0;
      m_cnt = 0;
      m_err = 1'b0;
   endfunction

   function automatic void m_step(input bit sh, input bit hd, input bit cm);
      if (cm) begin
         if (!sh && m_cnt == CL && m_parity_ok()) begin
            for (int j = 0; j < NMUX; j++) begin
               m_sel[j] = 0;
               for (int b = 0; b < SEL_W; b++)
                  m_sel[j] += int'(m_chain(j * SEL_W + b)) << b;
            end
            m_cnt = 0;
         end else
            m_err = 1'b1;
      end
      if (sh) begin
         if (m_cnt == CL) m_err = 1'b1;
         else m_cnt++;
         hist.push_back(hd);
      end
   endfunction

   task automatic check_state(input string tag);
      logic [CHAN_W-1:0] et, er;
      int idx;
      bit etail;
      for (int j = 0; j < CHAN_W; j++) begin
         et[j] = (m_sel[j] == 0) ? chanx_right_in[j] : (m_sel[j] == 1) ? top_pin_in : 1'b0;
         if (m_sel[CHAN_W + j] == 0)
            er[j] = chany_top_in[j];
         else if (m_sel[CHAN_W + j] <= N_PINS)
            er[j] = right_pin_in[m_sel[CHAN_W + j] - 1];
         else
            er[j] = 1'b0;
      end
      idx   = hist.size() - 1 - CL;
      etail = (idx >= 0) ? hist[idx] : 1'b0;
      check({tag, ".top"},   32'(chany_top_out),   32'(et));
      check({tag, ".right"}, 32'(chanx_right_out), 32'(er));
      check({tag, ".done"},  32'(cfg_done),        32'(m_cnt == CL));
      check({tag, ".err"},   32'(cfg_err),         32'(m_err));
      check({tag, ".tail"},  32'(ccff_tail),       32'(etail));
   endtask

   task automatic cycle(input bit sh, input bit hd, input bit cm);
      ccff_shift_en = sh;
      ccff_head     = hd;
      cfg_commit    = cm;
      @(posedge prog_clk);
      #1;
      m_step(sh, hd, cm);
      ccff_shift_en = 1'b0;
      cfg_commit    = 1'b0;
      check_state("cyc");
   endtask

   task automatic do_reset();
      prog_reset_n = 1'b0;
      #3;
      m_reset();
      check_state("rst");
      @(posedge prog_clk);
      #1;
      prog_reset_n = 1'b1;
   endtask

   task automatic rand_inputs();
      chany_top_in   = CHAN_W'($urandom);
      chanx_right_in = CHAN_W'($urandom);
      top_pin_in     = 1'($urandom);
      right_pin_in   = N_PINS'($urandom);
   endtask

   // Last mux first, MSB first; the parity bit (if any) leads the stream.
   task automatic load_sels(input int s[NMUX], input bit bad_par);
      bit q[$];
      bit p;
      p = bad_par;
      for (int j = 0; j < NMUX; j++)
         for (int b = 0; b < SEL_W; b++) p ^= 1'((s[j] >> b) & 1);
`ifdef SB_CFG_PARITY_EN
      q.push_back(p);
`endif
      for (int j = NMUX - 1; j >= 0; j--)
         for (int b = SEL_W - 1; b >= 0; b--) q.push_back(1'((s[j] >> b) & 1));
      foreach (q[i]) cycle(1'b1, q[i], 1'b0);
   endtask

   initial begin
      prog_reset_n   = 1'b0;
      ccff_head      = 1'b0;
      ccff_shift_en  = 1'b0;
      cfg_commit     = 1'b0;
      chany_top_in   = 11'h5A5;
      chanx_right_in = 11'h2C3;
      top_pin_in     = 1'b1;
      right_pin_in   = '0;

      // Reset: straight-through routing
      #3;
      m_reset();
      check("rst_right_pass", 32'(chanx_right_out), 32'h5A5);
      check("rst_top_pass",   32'(chany_top_out),   32'h2C3);
      check("rst_done",       32'(cfg_done),        32'h0);
      check("rst_err",        32'(cfg_err),         32'h0);
      @(posedge prog_clk);
      #1;
      prog_reset_n = 1'b1;
      cycle(1'b0, 1'b0, 1'b0);

      // Right mux 0 -> right_pin_in[2]
      for (int j = 0; j < NMUX; j++) sels[j] = 0;
      sels[CHAN_W] = 3;
      load_sels(sels, 1'b0);
      check("full_done", 32'(cfg_done), 32'h1);
      cycle(1'b0, 1'b0, 1'b1);
      check("commit_done_drop", 32'(cfg_done), 32'h0);
      right_pin_in = 6'b000100;
      #1;
      check("pin2_hi", 32'(chanx_right_out[0]), 32'h1);
      right_pin_in = 6'b111011;
      #1;
      check("pin2_lo", 32'(chanx_right_out[0]), 32'h0);
      rand_inputs();
      #1;
      check_state("comb");

      // Early commit after 40 bits
      do_reset();
      for (int i = 0; i < 40; i++) cycle(1'b1, 1'($urandom), 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      check("early_commit_err", 32'(cfg_err), 32'h1);
      for (int i = 40; i < CL; i++) cycle(1'b1, 1'($urandom), 1'b0);
      check("resume_done", 32'(cfg_done), 32'h1);

      // Overrun by one bit
      do_reset();
      for (int i = 0; i < CL; i++) cycle(1'b1, 1'($urandom), 1'b0);
      check("ovr_done", 32'(cfg_done), 32'h1);
      check("ovr_no_err_yet", 32'(cfg_err), 32'h0);
      cycle(1'b1, 1'($urandom), 1'b0);
      check("ovr_err", 32'(cfg_err), 32'h1);

      // Top mux sel 5 parks at 0; commit with shift is refused
      do_reset();
      for (int j = 0; j < NMUX; j++) sels[j] = $urandom_range(0, 7);
      sels[2] = 5;
      load_sels(sels, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      chanx_right_in = '1;
      top_pin_in     = 1'b1;
      #1;
      check("top_sel5_zero", 32'(chany_top_out[2]), 32'h0);
      for (int j = 0; j < NMUX; j++) sels[j] = $urandom_range(0, 7);
      load_sels(sels, 1'b0);
      cycle(1'b1, 1'($urandom), 1'b1);
      check("commit_shift_err", 32'(cfg_err), 32'h1);

`ifdef SB_CFG_PARITY_EN
      // Odd parity rejected, corrected stream accepted
      do_reset();
      for (int j = 0; j < NMUX; j++) sels[j] = $urandom_range(0, 7);
      load_sels(sels, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      check("par_reject_err",  32'(cfg_err),  32'h1);
      check("par_reject_full", 32'(cfg_done), 32'h1);
      load_sels(sels, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      check("par_accept_idle", 32'(cfg_done), 32'h0);
`endif

      // Random bitstreams, commits and input noise
      for (int r = 0; r < 12; r++) begin
         if ($urandom_range(0, 2) == 0) do_reset();
         for (int j = 0; j < NMUX; j++) sels[j] = $urandom_range(0, 7);
         load_sels(sels, $urandom_range(0, 3) == 0);
         cycle($urandom_range(0, 4) == 0, 1'($urandom), 1'b1);
         repeat (3) begin
            rand_inputs();
            #1;
            check_state("comb");
         end
      end
      repeat (400) begin
         if ($urandom_range(0, 6) == 0) rand_inputs();
         cycle(1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
         if ($urandom_range(0, 149) == 0) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
